// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS-subset control FSM.
package mc_ctrl_pkg;

  localparam int unsigned STATE_W = 5;
  localparam int unsigned WAIT_W  = 2;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned OP_W    = 6;

  typedef enum logic [STATE_W-1:0] {
    ST_RST      = 5'd0,
    ST_FETCH    = 5'd1,
    ST_DECODE   = 5'd2,
    ST_EXEC_R   = 5'd3,
    ST_WB_R     = 5'd4,
    ST_EXEC_I   = 5'd5,
    ST_WB_I     = 5'd6,
    ST_MEM_ADDR = 5'd7,
    ST_MEM_RD   = 5'd8,
    ST_WB_LW    = 5'd9,
    ST_MEM_WR   = 5'd10,
    ST_BRANCH   = 5'd11,
    ST_JUMP     = 5'd12,
    ST_EXC      = 5'd13
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [OP_W-1:0] FN_ADD = 6'h20;
  localparam logic [OP_W-1:0] FN_SUB = 6'h22;
  localparam logic [OP_W-1:0] FN_AND = 6'h24;
  localparam logic [OP_W-1:0] FN_OR  = 6'h25;
  localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

  // ALU operation codes
  localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 3'b100;

  // ALU source-B mux selects
  localparam logic [1:0] SRCB_REG      = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_SEXT     = 2'b10;
  localparam logic [1:0] SRCB_SEXT_SL2 = 2'b11;

  // PC mux selects (exception vector select is a module parameter)
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Datapath control bundle, excluding the separately decoded alu_op
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_wr;
    logic       ir_write;
    logic       a_b_load;
    logic       alu_out_load;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] pc_source;
    logic       epc_write;
  } ctrl_t;

  // True for the R-type functs this datapath implements
  function automatic logic funct_is_valid(input logic [OP_W-1:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
           (funct == FN_OR)  || (funct == FN_SLT);
  endfunction

  // True for the R-type functs whose signed overflow is architecturally visible
  function automatic logic funct_can_ovf(input logic [OP_W-1:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB);
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Instruction-field / ALU-flag inputs and datapath control outputs of the control FSM.
interface mc_ctrl_fsm_if;
  import mc_ctrl_pkg::*;

  logic [OP_W-1:0]    opcode;
  logic [OP_W-1:0]    funct;
  logic               alu_zero;
  logic               alu_overflow;
  logic               pc_write;
  logic               pc_write_cond;
  logic               i_or_d;
  logic               mem_wr;
  logic               ir_write;
  logic               a_b_load;
  logic               alu_out_load;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               reg_write;
  logic [1:0]         pc_source;
  logic               epc_write;
  logic [STATE_W-1:0] state_dbg;

  // Controller side
  modport master (
    input  opcode, funct, alu_zero, alu_overflow,
    output pc_write, pc_write_cond, i_or_d, mem_wr, ir_write, a_b_load,
           alu_out_load, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
           reg_write, pc_source, epc_write, state_dbg
  );

  // Datapath side
  modport slave (
    output opcode, funct, alu_zero, alu_overflow,
    input  pc_write, pc_write_cond, i_or_d, mem_wr, ir_write, a_b_load,
           alu_out_load, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
           reg_write, pc_source, epc_write, state_dbg
  );

endinterface

// File: rtl/mc_alu_op_dec.sv
// ALU operation decode from the controller state and the R-type funct field.
module mc_alu_op_dec
  import mc_ctrl_pkg::*;
(
  input  state_e             state,
  input  logic [OP_W-1:0]    funct,
  output logic [ALUOP_W-1:0] alu_op_c
);

  // Add by default (PC+4, branch target, address calc); funct selects in EXEC_R
  always_comb begin
    alu_op_c = ALU_ADD;
    case (state)
      ST_EXEC_R: begin
        case (funct)
          FN_SUB:  alu_op_c = ALU_SUB;
          FN_AND:  alu_op_c = ALU_AND;
          FN_OR:   alu_op_c = ALU_OR;
          FN_SLT:  alu_op_c = ALU_SLT;
          default: alu_op_c = ALU_ADD;
        endcase
      end
      ST_BRANCH, ST_EXC: alu_op_c = ALU_SUB;
      default:           alu_op_c = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM for the multicycle MIPS-subset datapath.
// Optional feature macro MC_CTRL_OVF_EXC_EN: when defined, signed overflow in
// EXEC_R (add/sub) or EXEC_I diverts to EXC instead of writing back.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_CYCLES = 1,
  parameter logic [1:0]  EXC_VECTOR_SEL  = 2'b11
)
(
  input logic          clk,
  input logic          reset_n,
  mc_ctrl_fsm_if.master bus
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_CYCLES);

  state_e             state;
  state_e             state_nxt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [WAIT_W-1:0]  wait_cnt_nxt;
  logic               wait_done_c;
  logic               ovf_trap_c;
  ctrl_t              ctrl_c;
  logic [ALUOP_W-1:0] alu_op_c;

  assign wait_done_c = (wait_cnt == WAIT_LAST);

`ifdef MC_CTRL_OVF_EXC_EN
  logic unused_zero;
  assign ovf_trap_c  = bus.alu_overflow;
  assign unused_zero = bus.alu_zero;
`else
  logic unused_flags;
  assign ovf_trap_c   = 1'b0;
  assign unused_flags = bus.alu_zero ^ bus.alu_overflow;
`endif

  // State and wait counter; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_RST;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next state, wait counter and Moore control decode
  always_comb begin
    state_nxt    = ST_RST;
    wait_cnt_nxt = '0;
    ctrl_c       = '0;
    case (state)
      ST_RST: begin
        state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        ctrl_c.alu_src_b = SRCB_FOUR;
        ctrl_c.pc_source = PCSRC_ALU;
        ctrl_c.ir_write  = wait_done_c;
        ctrl_c.pc_write  = wait_done_c;
        if (wait_done_c) begin
          state_nxt = ST_DECODE;
        end else begin
          state_nxt    = ST_FETCH;
          wait_cnt_nxt = WAIT_W'(wait_cnt + 1'b1);
        end
      end
      ST_DECODE: begin
        ctrl_c.a_b_load     = 1'b1;
        ctrl_c.alu_src_b    = SRCB_SEXT_SL2;
        ctrl_c.alu_out_load = 1'b1;
        case (bus.opcode)
          OP_RTYPE:     state_nxt = funct_is_valid(bus.funct) ? ST_EXEC_R : ST_EXC;
          OP_ADDI:      state_nxt = ST_EXEC_I;
          OP_LW, OP_SW: state_nxt = ST_MEM_ADDR;
          OP_BEQ:       state_nxt = ST_BRANCH;
          OP_J:         state_nxt = ST_JUMP;
          default:      state_nxt = ST_EXC;
        endcase
      end
      ST_EXEC_R: begin
        ctrl_c.alu_src_a    = 1'b1;
        ctrl_c.alu_src_b    = SRCB_REG;
        ctrl_c.alu_out_load = 1'b1;
        state_nxt = (ovf_trap_c && funct_can_ovf(bus.funct)) ? ST_EXC : ST_WB_R;
      end
      ST_WB_R: begin
        ctrl_c.reg_dst   = 1'b1;
        ctrl_c.reg_write = 1'b1;
        state_nxt        = ST_FETCH;
      end
      ST_EXEC_I: begin
        ctrl_c.alu_src_a    = 1'b1;
        ctrl_c.alu_src_b    = SRCB_SEXT;
        ctrl_c.alu_out_load = 1'b1;
        state_nxt = ovf_trap_c ? ST_EXC : ST_WB_I;
      end
      ST_WB_I: begin
        ctrl_c.reg_write = 1'b1;
        state_nxt        = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        ctrl_c.alu_src_a    = 1'b1;
        ctrl_c.alu_src_b    = SRCB_SEXT;
        ctrl_c.alu_out_load = 1'b1;
        state_nxt = (bus.opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        ctrl_c.i_or_d = 1'b1;
        if (wait_done_c) begin
          state_nxt = ST_WB_LW;
        end else begin
          state_nxt    = ST_MEM_RD;
          wait_cnt_nxt = WAIT_W'(wait_cnt + 1'b1);
        end
      end
      ST_WB_LW: begin
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.reg_write  = 1'b1;
        state_nxt         = ST_FETCH;
      end
      ST_MEM_WR: begin
        ctrl_c.i_or_d = 1'b1;
        ctrl_c.mem_wr = 1'b1;
        if (wait_done_c) begin
          state_nxt = ST_FETCH;
        end else begin
          state_nxt    = ST_MEM_WR;
          wait_cnt_nxt = WAIT_W'(wait_cnt + 1'b1);
        end
      end
      ST_BRANCH: begin
        ctrl_c.alu_src_a     = 1'b1;
        ctrl_c.alu_src_b     = SRCB_REG;
        ctrl_c.pc_write_cond = 1'b1;
        ctrl_c.pc_source     = PCSRC_ALUOUT;
        state_nxt            = ST_FETCH;
      end
      ST_JUMP: begin
        ctrl_c.pc_write  = 1'b1;
        ctrl_c.pc_source = PCSRC_JUMP;
        state_nxt        = ST_FETCH;
      end
      ST_EXC: begin
        ctrl_c.alu_src_b = SRCB_FOUR;
        ctrl_c.epc_write = 1'b1;
        ctrl_c.pc_write  = 1'b1;
        ctrl_c.pc_source = EXC_VECTOR_SEL;
        state_nxt        = ST_FETCH;
      end
      default: begin
        state_nxt = ST_RST;
      end
    endcase
  end

  mc_alu_op_dec u_alu_op_dec (
    .state    (state),
    .funct    (bus.funct),
    .alu_op_c (alu_op_c)
  );

  assign bus.pc_write      = ctrl_c.pc_write;
  assign bus.pc_write_cond = ctrl_c.pc_write_cond;
  assign bus.i_or_d        = ctrl_c.i_or_d;
  assign bus.mem_wr        = ctrl_c.mem_wr;
  assign bus.ir_write      = ctrl_c.ir_write;
  assign bus.a_b_load      = ctrl_c.a_b_load;
  assign bus.alu_out_load  = ctrl_c.alu_out_load;
  assign bus.alu_src_a     = ctrl_c.alu_src_a;
  assign bus.alu_src_b     = ctrl_c.alu_src_b;
  assign bus.alu_op        = alu_op_c;
  assign bus.reg_dst       = ctrl_c.reg_dst;
  assign bus.mem_to_reg    = ctrl_c.mem_to_reg;
  assign bus.reg_write     = ctrl_c.reg_write;
  assign bus.pc_source     = ctrl_c.pc_source;
  assign bus.epc_write     = ctrl_c.epc_write;
  assign bus.state_dbg     = state;

endmodule
